// File: rtl/operand_feeder_pkg.sv
// operand_feeder shared types and widths.
// Widths are shared with the multiplier datapath and controller.
package operand_feeder_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OFFER,
    DONE
  } state_t;

endpackage

// File: rtl/operand_feeder_if.sv
// Operand pair stream from the feeder to the multiplier controller.
// Master drives the pair and valid; slave returns ready.
interface operand_feeder_if
  import operand_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [ADDR_W-1:0] out_idx;
  logic              out_zero;

  modport master (
    output out_valid,
    output out_a,
    output out_b,
    output out_idx,
    output out_zero,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_a,
    input  out_b,
    input  out_idx,
    input  out_zero,
    output out_ready
  );

endinterface

// File: rtl/operand_feeder_bank.sv
// operand_bank: DEPTH x 2 operand register file.
// One write port, one combinational read port, async clear.
module operand_bank
  import operand_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (wr_en) begin
      mem_a[wr_addr] <= wr_a;
      mem_b[wr_addr] <= wr_b;
    end
  end

  assign rd_a = mem_a[rd_addr];
  assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/operand_feeder.sv
// operand_feeder: streams stored operand pairs to the multiplier.
// Zero operands are flagged so the controller can skip normalisation.
module operand_feeder
  import operand_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_a,
  input  logic [DATA_W-1:0] wr_b,
  input  logic              start,
  output logic              busy,
  output logic              done,
  operand_feeder_if.master  feed
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nx;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // bank is frozen while a batch runs
  operand_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en & ~busy),
    .wr_addr (wr_addr),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .rd_addr (ptr),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: begin
        if (start) begin
          ptr_nx   = '0;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = OFFER;
      OFFER: begin
        if (feed.out_ready) begin
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state_nx = DONE;
          end else begin
            ptr_nx   = ptr + 1'b1;
            state_nx = LOAD;
          end
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ptr           <= '0;
      feed.out_a    <= '0;
      feed.out_b    <= '0;
      feed.out_idx  <= '0;
      feed.out_zero <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      if (state == LOAD) begin
        feed.out_a    <= rd_a;
        feed.out_b    <= rd_b;
        feed.out_idx  <= ptr;
        feed.out_zero <= (rd_a == '0) || (rd_b == '0);
      end
    end
  end

  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign feed.out_valid = (state == OFFER);

endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder.
// Scoreboard of expected pairs, pushed at start and popped on handshake.
module tb_operand_feeder;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] idx;
    logic          zero;
  } pair_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          zero;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_a;
  logic [DW-1:0] wr_b;
  logic          start;
  logic          busy;
  logic          done;

  operand_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) feed ();

  operand_feeder #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .feed    (feed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  pair_t sb[$];
  logic [DW-1:0] ma [DEPTH];
  logic [DW-1:0] mb [DEPTH];
  logic          mz [DEPTH];
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst && feed.out_valid && feed.out_ready) begin
      pair_t got;
      got = '{feed.out_a, feed.out_b, feed.out_idx, feed.out_zero};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra act=%h exp=none", got);
      end else begin
        chk("pair", 64'(got), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input vec_t v, input bit upd);
    wr_en   = 1'b1;
    wr_addr = v.addr;
    wr_a    = v.a;
    wr_b    = v.b;
    tick();
    wr_en = 1'b0;
    if (upd) begin
      ma[v.addr] = v.a;
      mb[v.addr] = v.b;
      mz[v.addr] = v.zero;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      sb.push_back('{ma[i], mb[i], AW'(i), mz[i]});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout act=%0d exp=done", cyc);
    end
  endtask

  task automatic wait_pair(input int k);
    int n = 0;
    while (!(feed.out_valid && feed.out_idx == AW'(k)) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL pair_timeout act=none exp=idx%0d", k);
    end
  endtask

  initial begin
    int cyc;
    int dc0;
    vec_t bad;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{AW'(i), 16'h0100 + 16'(i), 16'(16'h8000 >> i), 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[8+i] = '{AW'(i),
                   (i == 2) ? 16'h0000 : 16'h1230 + 16'(i),
                   (i == 5) ? 16'h0000 : 16'h00F0 | 16'(i),
                   (i == 2 || i == 5)};
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      mz[i] = 1'b1;
    end
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_a = '0;
    wr_b = '0;
    start = 1'b0;
    feed.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ctl", {61'd0, busy, feed.out_valid, done}, 64'd0);
    chk("rst_data", {feed.out_a, feed.out_b, 12'd0, feed.out_idx,
                     feed.out_zero}, 64'd0);
    rst = 1'b1;
    tick();
    chk("rel_ctl", {61'd0, busy, feed.out_valid, done}, 64'd0);
    chk("rel_data", {feed.out_a, feed.out_b, 12'd0, feed.out_idx,
                     feed.out_zero}, 64'd0);

    // basic batch
    for (int i = 0; i < 8; i++) wr(tbl[i], 1'b1);
    dc0 = done_cnt;
    do_start();
    chk("busy_rise", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("done_cycle", 64'(cyc), 64'd17);
    tick();
    chk("busy_fall", {62'd0, busy, done}, 64'd0);
    chk("done_once", 64'(done_cnt - dc0), 64'd1);
    chk("sb_empty1", 64'(sb.size()), 64'd0);

    // backpressure on pair 3
    do_start();
    wait_pair(3);
    feed.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", {feed.out_valid, 12'd0, feed.out_idx, feed.out_a,
                      feed.out_b}, {1'b1, 12'd0, 3'd3, ma[3], mb[3]});
    end
    feed.out_ready = 1'b1;
    tick();
    chk("bp_load", 64'(feed.out_valid), 64'd0);
    tick();
    chk("bp_next", {60'd0, feed.out_valid, feed.out_idx}, {60'd0, 4'b1100});
    wait_done(cyc);
    tick();
    chk("sb_empty2", 64'(sb.size()), 64'd0);

    // zero flags
    for (int i = 8; i < 16; i++) wr(tbl[i], 1'b1);
    do_start();
    wait_done(cyc);
    chk("done_cycle_z", 64'(cyc), 64'd17);
    tick();
    chk("sb_empty3", 64'(sb.size()), 64'd0);

    // write and start while busy are dropped
    dc0 = done_cnt;
    do_start();
    repeat (3) tick();
    bad = '{3'd0, 16'hDEAD, 16'hBEEF, 1'b0};
    wr(bad, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    tick();
    repeat (3) tick();
    chk("ign_busy", 64'(busy), 64'd0);
    chk("ign_done", 64'(done_cnt - dc0), 64'd1);
    do_start();
    wait_done(cyc);
    tick();
    chk("sb_empty4", 64'(sb.size()), 64'd0);

    // reset during OFFER of pair 4
    dc0 = done_cnt;
    do_start();
    wait_pair(4);
    feed.out_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst", {61'd0, busy, feed.out_valid, done}, 64'd0);
    sb.delete();
    for (int i = 0; i < DEPTH; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      mz[i] = 1'b1;
    end
    repeat (2) tick();
    chk("mid_nodone", 64'(done_cnt - dc0), 64'd0);
    rst = 1'b1;
    tick();
    feed.out_ready = 1'b1;
    do_start();
    wait_done(cyc);
    tick();
    chk("sb_empty5", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
